change_dispenser: RTL

Downstream stage of the vending FSM. It takes the 16-bit change amount (O_CHANGE, in cents) produced after a successful sale and pays it out one coin at a time to a coin hopper over a valid/ack handshake. Coin selection is greedy and limited by an on-block per-denomination coin inventory. Any amount it cannot pay is reported as a shortfall.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/coin_inventory.sv | 57 +++++
 rtl/change_dispenser.sv | 109 ++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending types: money width, coin denominations and the
// change-dispenser state encoding.
package vend_pkg;

   localparam int N_DENOM = 6;

   typedef logic [15:0] money_t;
   typedef logic [2:0]  denom_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_ISSUE,
      S_FINISH
   } state_t;

   // Coin value in cents, largest first so index order is greedy order.
   function automatic money_t coin_value(input denom_t d);
      money_t v;
      case (d)
         3'd0:    v = 16'd500;
         3'd1:    v = 16'd100;
         3'd2:    v = 16'd25;
         3'd3:    v = 16'd10;
         3'd4:    v = 16'd5;
         3'd5:    v = 16'd1;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/coin_inventory.sv
// Per-denomination coin counters with saturating refill and a
// single decrement port driven by the hopper handshake.
module coin_inventory
   import vend_pkg::*;
#(
   parameter int INIT_COUNT = 20,
   parameter int CNT_W      = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             refill,
   input  denom_t                           refill_denom,
   input  logic [7:0]                       refill_cnt,
   input  logic                             dec,
   input  denom_t                           dec_denom,
   output logic [N_DENOM-1:0][CNT_W-1:0]    counts,
   output logic [N_DENOM-1:0]               nonzero
);

   localparam int SW = CNT_W + 9;
   localparam logic [SW-1:0] MAX =
      {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

   logic [SW-1:0]                   sum [N_DENOM];
   logic [N_DENOM-1:0][CNT_W-1:0]   nxt;

   // Refill and take can hit the same counter in one cycle; they
   // combine before saturation so neither is lost.
   always_comb begin
      nxt = counts;
      for (int i = 0; i < N_DENOM; i++) begin
         sum[i] = SW'(counts[i]);
         if (refill && refill_denom == denom_t'(i))
            sum[i] = sum[i] + SW'(refill_cnt);
         if (dec && dec_denom == denom_t'(i) && counts[i] != '0)
            sum[i] = sum[i] - SW'(1);
         nxt[i] = (sum[i] > MAX) ? MAX[CNT_W-1:0]
                                 : sum[i][CNT_W-1:0];
      end
   end

   always_comb begin
      nonzero = '0;
      for (int i = 0; i < N_DENOM; i++)
         nonzero[i] = (counts[i] != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_DENOM; i++)
            counts[i] <= CNT_W'(INIT_COUNT);
      end else begin
         counts <= nxt;
      end
   end

endmodule

// File: rtl/change_dispenser.sv
// Pays a change amount one coin at a time to the hopper, greedy by
// value and limited by the coin inventory; reports any shortfall.
module change_dispenser
   import vend_pkg::*;
#(
   parameter int INIT_COUNT = 20,
   parameter int CNT_W      = 8
) (
   input  logic        CLK,
   input  logic        I_RESET,
   input  logic        I_LOAD,
   input  logic [15:0] I_AMOUNT,
   input  logic        I_COIN_ACK,
   input  logic        I_REFILL,
   input  logic [2:0]  I_REFILL_DENOM,
   input  logic [7:0]  I_REFILL_CNT,
   output logic        O_COIN_VALID,
   output logic [2:0]  O_COIN_DENOM,
   output logic        O_BUSY,
   output logic        O_DONE,
   output logic [15:0] O_SHORT,
   output logic        O_ERROR
);

   state_t                        state;
   money_t                        remaining;
   denom_t                        pick;
   logic                          found;
   logic                          take;
   logic [N_DENOM-1:0]            nonzero;
   logic [N_DENOM-1:0][CNT_W-1:0] counts;

   assign take = (state == S_ISSUE) && I_COIN_ACK;

   coin_inventory #(
      .INIT_COUNT (INIT_COUNT),
      .CNT_W      (CNT_W)
   ) u_inv (
      .clk          (CLK),
      .reset        (I_RESET),
      .refill       (I_REFILL),
      .refill_denom (I_REFILL_DENOM),
      .refill_cnt   (I_REFILL_CNT),
      .dec          (take),
      .dec_denom    (O_COIN_DENOM),
      .counts       (counts),
      .nonzero      (nonzero)
   );

   // Scan downward so the lowest (largest-value) index wins.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = N_DENOM - 1; i >= 0; i--) begin
         if (nonzero[i] &&
             coin_value(denom_t'(i)) <= remaining) begin
            pick  = denom_t'(i);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (I_RESET) begin
         state        <= S_IDLE;
         remaining    <= '0;
         O_COIN_DENOM <= '0;
         O_SHORT      <= '0;
         O_ERROR      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (I_LOAD) begin
                  remaining <= I_AMOUNT;
                  O_SHORT   <= '0;
                  O_ERROR   <= 1'b0;
                  state     <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (remaining == '0) begin
                  state <= S_FINISH;
               end else if (found) begin
                  O_COIN_DENOM <= pick;
                  state        <= S_ISSUE;
               end else begin
                  O_SHORT <= remaining;
                  O_ERROR <= 1'b1;
                  state   <= S_FINISH;
               end
            end
            S_ISSUE: begin
               if (I_COIN_ACK) begin
                  remaining <= remaining -
                               coin_value(O_COIN_DENOM);
                  state     <= S_SELECT;
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

   assign O_COIN_VALID = (state == S_ISSUE);
   assign O_DONE       = (state == S_FINISH);
   assign O_BUSY       = (state != S_IDLE);

endmodule
